// File: rtl/capture_sched_pkg.sv
// Shared constants for the capture line scheduler: state encoding, default
// resolution and the widths of the position, line and drop-counter fields.
package capture_sched_pkg;

   localparam int CS_H_RES_DEF = 640;
   localparam int CS_V_RES_DEF = 480;
   localparam int CS_HPOS_W    = 10;
   localparam int CS_VPOS_W    = 9;
   localparam int CS_DROP_W    = 8;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
   localparam logic [1:0] ST_CAPTURE    = 2'd2;
   localparam logic [1:0] ST_DRAIN      = 2'd3;

   function automatic logic [CS_DROP_W-1:0] sat_inc(input logic [CS_DROP_W-1:0] v);
      return (v == '1) ? v : (v + CS_DROP_W'(1));
   endfunction

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Full flags and line numbers of the two line banks; presents the oldest full bank.
// Request is combinational from state; an accepted ack frees the bank on the next edge.
module pingpong_bank_tracker
   import capture_sched_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_mark,
   input  logic                 i_mark_bank,
   input  logic [CS_VPOS_W-1:0] i_mark_line,
   input  logic                 i_ack,
   output logic [1:0]           o_full,
   output logic                 o_req,
   output logic                 o_bank,
   output logic [CS_VPOS_W-1:0] o_line
);

   logic [1:0]           r_full;
   logic                 r_head;
   logic [CS_VPOS_W-1:0] r_line [2];
   logic                 w_req;
   logic                 w_ack;

   // Banks are marked strictly alternately, so a single head pointer that
   // toggles on every accepted ack always names the oldest pending bank.
   assign w_req  = r_full[r_head];
   assign w_ack  = i_ack & w_req;
   assign o_req  = w_req;
   assign o_bank = w_req & r_head;
   assign o_line = w_req ? r_line[r_head] : '0;
   assign o_full = r_full;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_full    <= 2'b00;
         r_head    <= 1'b0;
         r_line[0] <= '0;
         r_line[1] <= '0;
      end else begin
         if (w_ack) begin
            r_full[r_head] <= 1'b0;
            r_head         <= ~r_head;
         end
         if (i_mark) begin
            r_full[i_mark_bank] <= 1'b1;
            r_line[i_mark_bank] <= i_mark_line;
         end
      end
   end

endmodule

// File: rtl/capture_line_scheduler.sv
// Captures video lines into a ping-pong buffer and hands full lines to a memory writer.
// Buffer writes lag input by one cycle; lines are dropped when no bank is free.
module capture_line_scheduler
   import capture_sched_pkg::*;
#(
   parameter int H_RES_PIX      = CS_H_RES_DEF,
   parameter int V_RES_PIX      = CS_V_RES_DEF,
   parameter int BITS_PER_PIXEL = 24
) (
   input  logic                      vid_clk,
   input  logic                      reset,
   input  logic                      capture_en,
   input  logic                      single_shot,
   input  logic [CS_HPOS_W-1:0]      Hpos,
   input  logic [CS_VPOS_W-1:0]      Vpos,
   input  logic                      VidEn,
   input  logic [BITS_PER_PIXEL-1:0] pixel_in,
   input  logic                      line_ready,
   input  logic                      frame_ready,
   output logic                      buf_we,
   output logic                      buf_sel,
   output logic [CS_HPOS_W-1:0]      buf_waddr,
   output logic [BITS_PER_PIXEL-1:0] buf_wdata,
   output logic                      xfer_req,
   output logic                      xfer_bank,
   output logic [CS_VPOS_W-1:0]      xfer_line,
   input  logic                      xfer_ack,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      overflow,
   output logic [CS_DROP_W-1:0]      drop_cnt
);

   localparam logic [CS_HPOS_W-1:0] H_LIM = CS_HPOS_W'(H_RES_PIX);
   localparam logic [CS_VPOS_W-1:0] V_LIM = CS_VPOS_W'(V_RES_PIX);

   logic [1:0]                r_rst_sync;
   logic [1:0]                r_state;
   logic                      r_wbank;
   logic                      r_we;
   logic                      r_sel;
   logic [CS_HPOS_W-1:0]      r_waddr;
   logic [BITS_PER_PIXEL-1:0] r_wdata;
   logic                      r_frame_done;
   logic                      r_overflow;
   logic [CS_DROP_W-1:0]      r_drop_cnt;

   logic                      w_rst_n;
   logic                      w_in_capture;
   logic                      w_wr;
   logic                      w_ack;
   logic                      w_wbank_free;
   logic                      w_mark;
   logic                      w_drop;
   logic [1:0]                w_full;

   // Assert asynchronously, release two edges after reset rises.
   always_ff @(posedge vid_clk or negedge reset) begin
      if (!reset) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_in_capture = (r_state == ST_CAPTURE);
   assign w_wr         = w_in_capture & VidEn & (Hpos < H_LIM) & (Vpos < V_LIM);
   assign w_ack        = xfer_ack & xfer_req;
   // When both banks are full the write bank is the oldest one, so an ack in
   // the same cycle frees exactly the bank this line_ready wants to mark.
   assign w_wbank_free = ~w_full[r_wbank] | (w_ack & (xfer_bank == r_wbank));
   assign w_mark       = w_in_capture & line_ready & w_wbank_free;
   assign w_drop       = w_in_capture & line_ready & ~w_wbank_free;

   pingpong_bank_tracker u_tracker (
      .i_clk       (vid_clk),
      .i_rst_n     (w_rst_n),
      .i_mark      (w_mark),
      .i_mark_bank (r_wbank),
      .i_mark_line (Vpos),
      .i_ack       (xfer_ack),
      .o_full      (w_full),
      .o_req       (xfer_req),
      .o_bank      (xfer_bank),
      .o_line      (xfer_line)
   );

   always_ff @(posedge vid_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state      <= ST_IDLE;
         r_wbank      <= 1'b0;
         r_we         <= 1'b0;
         r_sel        <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_frame_done <= 1'b0;
         r_we         <= w_wr;
         r_sel        <= w_wr & r_wbank;
         r_waddr      <= w_wr ? Hpos : '0;
         r_wdata      <= w_wr ? pixel_in : '0;
         if (w_mark) r_wbank <= ~r_wbank;
         if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= sat_inc(r_drop_cnt);
         end
         case (r_state)
            ST_IDLE: begin
               if (capture_en) begin
                  r_state    <= ST_WAIT_FRAME;
                  r_overflow <= 1'b0;
                  r_drop_cnt <= '0;
               end
            end
            ST_WAIT_FRAME: begin
               if (!capture_en)      r_state <= ST_IDLE;
               else if (frame_ready) r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (!capture_en) r_state <= ST_DRAIN;
               else if (frame_ready) begin
                  if (single_shot) r_state      <= ST_DRAIN;
                  else             r_frame_done <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_full == 2'b00) begin
                  r_frame_done <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign buf_we     = r_we;
   assign buf_sel    = r_sel;
   assign buf_waddr  = r_waddr;
   assign buf_wdata  = r_wdata;
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign drop_cnt   = r_drop_cnt;

endmodule
